// File: rtl/lsu_ctrl.sv
`default_nettype none
// lsu_ctrl: single-outstanding load/store controller in front of a 2**ADDR_W byte data memory.
// Splits word-crossing accesses into two memory cycles and aligns/extends load data.
module lsu_ctrl #(
  parameter int ADDR_W           = 11,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  output logic [3:0]        o_dmem_wren,
  input  logic [31:0]       i_dmem_q
);
  localparam int WA_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;

  // Accept-time decode of the incoming request
  logic [1:0]      off;
  logic [3:0]      size_mask;
  logic [7:0]      mask8;
  logic [63:0]     wdata64;
  logic [ADDR_W:0] end_byte;
  logic            size_err;
  logic            range_err;
  logic            align_err;
  logic            acc_err;

  always_comb begin
    off = i_req_addr[1:0];
    case (i_req_size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    mask8    = {4'b0000, size_mask} << off;
    wdata64  = {32'h0, i_req_wdata} << {off, 3'b000};
    end_byte = {1'b0, i_req_addr[ADDR_W-1:0]}
             + {{(ADDR_W-1){1'b0}}, i_req_size[1], |i_req_size};
    size_err  = (i_req_size == 2'b11);
    range_err = (i_req_addr[31:ADDR_W] != '0) || (end_byte > {1'b0, {ADDR_W{1'b1}}});
    align_err = !ALLOW_MISALIGNED
              && ((i_req_size == 2'b01 && off[0]) || (i_req_size == 2'b10 && off != 2'b00));
    acc_err   = size_err || range_err || align_err;
  end

  // Latched request
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_uns;
  logic [1:0]      req_off;
  logic            err_q;
  logic [WA_W-1:0] word_next;
  logic [31:0]     wdata_hi;
  logic [3:0]      mask_hi;
  logic [31:0]     lo_q;
  logic [31:0]     hi_q;
  logic [3:0]      wren_q;

  logic [31:0] shifted;
  logic [31:0] load_val;

  always_comb begin
    shifted = 32'({hi_q, lo_q} >> {req_off, 3'b000});
    case (req_size)
      2'b00:   load_val = req_uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = req_uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // A reset arriving mid-access must not write memory on the reset edge itself
  assign o_dmem_wren = i_reset ? 4'b0000 : wren_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      o_req_ready  <= 1'b1;
      o_rsp_valid  <= 1'b0;
      o_rsp_err    <= 1'b0;
      o_rsp_rdata  <= '0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      wren_q       <= '0;
      req_we       <= 1'b0;
      req_size     <= '0;
      req_uns      <= 1'b0;
      req_off      <= '0;
      err_q        <= 1'b0;
      word_next    <= '0;
      wdata_hi     <= '0;
      mask_hi      <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            o_req_ready  <= 1'b0;
            req_we       <= i_req_we;
            req_size     <= i_req_size;
            req_uns      <= i_req_unsigned;
            req_off      <= off;
            err_q        <= acc_err;
            word_next    <= i_req_addr[ADDR_W-1:2] + WA_W'(1);
            wdata_hi     <= wdata64[63:32];
            mask_hi      <= mask8[7:4];
            o_dmem_addr  <= {i_req_addr[ADDR_W-1:2], 2'b00};
            o_dmem_wdata <= wdata64[31:0];
            if (acc_err) begin
              state  <= RESP;
              wren_q <= 4'b0000;
            end else begin
              state  <= ACC0;
              wren_q <= i_req_we ? mask8[3:0] : 4'b0000;
            end
          end
        end
        ACC0: begin
          lo_q <= i_dmem_q;
          if (mask_hi != 4'b0000) begin
            state        <= ACC1;
            o_dmem_addr  <= {word_next, 2'b00};
            o_dmem_wdata <= wdata_hi;
            wren_q       <= req_we ? mask_hi : 4'b0000;
          end else begin
            state  <= RESP;
            wren_q <= 4'b0000;
          end
        end
        ACC1: begin
          hi_q   <= i_dmem_q;
          wren_q <= 4'b0000;
          state  <= RESP;
        end
        RESP: begin
          // First RESP cycle formats the result; valid is then held until consumed
          if (!o_rsp_valid) begin
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= err_q;
            o_rsp_rdata <= (err_q || req_we) ? 32'h0 : load_val;
          end else if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= '0;
            o_req_ready <= 1'b1;
            state       <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
`default_nettype wire
